// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// One request in flight. Read misses refill a whole line over a valid/ready
// word port, then re-run the lookup so the response always comes from the array.
module data_cache_dm #(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [2:0]            req_width,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int WOFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int AI_W    = WOFF_W + IDX_W;
  localparam int TAG_LSB = 2 + AI_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam int WA_W    = ADDR_WIDTH - 2;
  localparam int CNT_W   = (WOFF_W > 0) ? WOFF_W : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);
  localparam logic [WA_W-1:0]  LINE_MASK = WA_W'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_REFILL_REQ  = 3'd2;
  localparam logic [2:0] S_REFILL_WAIT = 3'd3;
  localparam logic [2:0] S_WRITE_MEM   = 3'd4;

  typedef struct packed {
    logic                  mode;
    logic [2:0]            width;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  logic [2:0]       state;
  req_t             rq;
  logic [CNT_W-1:0] cnt;
  logic [LINES-1:0] valid;

  logic [31:0]      data_arr [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_arr  [LINES];

  logic [WA_W-1:0]  wa, refill_wa;
  logic [AI_W-1:0]  ai, refill_ai;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic             hit, err, last;
  logic [3:0]       strb;
  logic [31:0]      wd, rd_word, rd_sh, ld;

  assign wa        = rq.addr[ADDR_WIDTH-1:2];
  assign ai        = wa[AI_W-1:0];
  assign idx       = rq.addr[TAG_LSB-1:2+WOFF_W];
  assign tag       = rq.addr[ADDR_WIDTH-1:TAG_LSB];
  assign off       = rq.addr[1:0];
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign refill_wa = (wa & ~LINE_MASK) | WA_W'(cnt);
  assign refill_ai = refill_wa[AI_W-1:0];
  assign last      = (cnt == CNT_LAST);
  assign rd_word   = data_arr[ai];
  assign rd_sh     = rd_word >> {off, 3'b000};

  // Misalignment and illegal width/mode combinations
  always_comb begin
    err = 1'b0;
    case (rq.width)
      3'b000:  err = 1'b0;
      3'b001:  err = off[0];
      3'b010:  err = |off;
      3'b100:  err = ~rq.mode;
      3'b101:  err = ~rq.mode | off[0];
      default: err = 1'b1;
    endcase
  end

  // Store lane placement and byte strobes
  always_comb begin
    strb = 4'b1111;
    wd   = rq.wdata;
    case (rq.width[1:0])
      2'b00: begin
        strb = 4'b0001 << off;
        wd   = 32'(rq.wdata[7:0]) << {off, 3'b000};
      end
      2'b01: begin
        strb = off[1] ? 4'b1100 : 4'b0011;
        wd   = 32'(rq.wdata[15:0]) << {off[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Load extraction and sign/zero extension
  always_comb begin
    case (rq.width)
      3'b000:  ld = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld = {24'b0, rd_sh[7:0]};
      3'b101:  ld = {16'b0, rd_sh[15:0]};
      default: ld = rd_word;
    endcase
  end

  // Output decode from state; everything idles at zero
  always_comb begin
    req_ready     = (state == S_IDLE) && !flush;
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    case (state)
      S_LOOKUP: begin
        if (err) begin
          resp_valid = 1'b1;
          resp_error = 1'b1;
        end else if (rq.mode && hit) begin
          resp_valid = 1'b1;
          resp_rdata = ld;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = refill_wa;
      end
      S_WRITE_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_addr      = wa;
        mem_wdata     = wd;
        mem_wstrb     = strb;
        resp_valid    = mem_ready;
      end
      default: ;
    endcase
  end

  // Control FSM, request latch, refill counter and valid bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      rq    <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) valid <= '0;
          else if (req_valid) begin
            rq    <= '{mode: req_mode, width: req_width, addr: req_addr, wdata: req_wdata};
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (err || (rq.mode && hit)) state <= S_IDLE;
          else if (rq.mode) begin
            // line is invalid while partially overwritten
            cnt        <= '0;
            valid[idx] <= 1'b0;
            state      <= S_REFILL_REQ;
          end else state <= S_WRITE_MEM;
        end
        S_REFILL_REQ: if (mem_ready) state <= S_REFILL_WAIT;
        S_REFILL_WAIT: begin
          if (mem_rvalid) begin
            if (last) begin
              valid[idx] <= 1'b1;
              state      <= S_LOOKUP;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_REFILL_REQ;
            end
          end
        end
        S_WRITE_MEM: if (mem_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays: refill words and write-hit byte merges
  always_ff @(posedge clk) begin
    if (state == S_REFILL_WAIT && mem_rvalid) begin
      data_arr[refill_ai] <= mem_rdata;
      if (last) tag_arr[idx] <= tag;
    end
    if (state == S_WRITE_MEM && mem_ready && hit) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) data_arr[ai][8*b +: 8] <= wd[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_cache_dm.sv
// Bench for data_cache_dm: directed vector table, flush/reset corner
// sequences, then random traffic against a word-level reference model.
module tb_data_cache_dm;
  localparam int LW = 4;
  localparam int NL = 16;

  logic        clk = 0, reset_n = 0, flush = 0, req_valid = 0, req_mode = 0;
  logic [2:0]  req_width = 0;
  logic [11:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  data_cache_dm #(.ADDR_WIDTH(12), .LINE_WORDS(LW), .LINES(NL)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // backing store behind the memory port, and the model's own view of memory
  logic [31:0] bmem [1024];
  logic [31:0] ref_mem [1024];
  bit          mv [NL];
  int          mt [NL];

  // memory-side observation
  int          rd_cnt, wr_cnt;
  int          rd_q[$];
  int          w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_data;

  // transaction results
  bit          got;
  logic [31:0] r_data;
  logic        r_err;
  int          lat;

  int  pend = 0, pend_addr = 0, pend_dly = 0;

  // Memory responder: random ready stalls, read data 1..3 cycles after accept
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 0; mem_rvalid = 0; mem_ready = 0;
    end else begin
      mem_rvalid = 0;
      if (pend != 0) begin
        if (pend_dly == 0) begin
          mem_rvalid = 1; mem_rdata = bmem[pend_addr]; pend = 0;
        end else pend_dly--;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      if (mem_req_valid && mem_ready) begin
        if (mem_req_write) begin
          wr_cnt++; w_addr = int'(mem_addr); w_strb = mem_wstrb; w_data = mem_wdata;
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bmem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          rd_cnt++; rd_q.push_back(int'(mem_addr));
          pend = 1; pend_addr = int'(mem_addr); pend_dly = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit exp_err(bit m, logic [2:0] w, int a);
    case (w)
      3'd0:    return 0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      3'd4:    return !m;
      3'd5:    return !m || (a % 2) != 0;
      default: return 1;
    endcase
  endfunction

  // Expected outcome from the cache rules; updates model state
  task automatic model_step(input bit m, input logic [2:0] w, input int a, input logic [31:0] d,
                            output bit e_err, output logic [31:0] e_data, output int e_rd,
                            output int e_wr, output logic [3:0] e_strb, output logic [31:0] e_wd);
    int idx, tg, off, wa;
    logic [31:0] word, sh;
    idx = (a >> 4) % NL; tg = a >> 8; off = a % 4; wa = a >> 2;
    e_err = exp_err(m, w, a); e_data = 0; e_rd = 0; e_wr = 0; e_strb = 0; e_wd = 0;
    if (e_err) return;
    if (m) begin
      if (!(mv[idx] && mt[idx] == tg)) begin
        e_rd = LW; mv[idx] = 1; mt[idx] = tg;
      end
      word = ref_mem[wa];
      sh = word >> (8 * off);
      case (w)
        3'd0:    e_data = {{24{sh[7]}}, sh[7:0]};
        3'd1:    e_data = {{16{sh[15]}}, sh[15:0]};
        3'd4:    e_data = {24'b0, sh[7:0]};
        3'd5:    e_data = {16'b0, sh[15:0]};
        default: e_data = word;
      endcase
    end else begin
      e_wr = 1;
      case (w)
        3'd0:    begin e_strb = 4'(1 << off); e_wd = (d & 32'hff) << (8 * off); end
        3'd1:    begin e_strb = 4'(3 << off); e_wd = (d & 32'hffff) << (8 * off); end
        default: begin e_strb = 4'hf; e_wd = d; end
      endcase
      for (int b = 0; b < 4; b++)
        if (e_strb[b]) ref_mem[wa][8*b +: 8] = e_wd[8*b +: 8];
    end
  endtask

  // Issue one request and wait (bounded) for its response
  task automatic xact(input bit m, input logic [2:0] w, input int a, input logic [31:0] d);
    int n;
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; rd_q.delete();
    req_valid = 1; req_mode = m; req_width = w; req_addr = 12'(a); req_wdata = d;
    @(posedge clk); #1 req_valid = 0;
    got = 0; n = 0;
    while (n < 300) begin
      @(negedge clk); #1; n++;
      if (resp_valid) begin
        got = 1; r_data = resp_rdata; r_err = resp_error; break;
      end
    end
    lat = n;
  endtask

  task automatic check_against(input string nm, input bit m, input int a,
                               input bit e_err, input logic [31:0] e_data, input int e_rd,
                               input int e_wr, input logic [3:0] e_strb, input logic [31:0] e_wd);
    chk({nm, " responded"}, 32'(got), 1);
    if (!got) return;
    chk({nm, " error"}, 32'(r_err), 32'(e_err));
    chk({nm, " rdata"}, r_data, e_data);
    chk({nm, " mem reads"}, rd_cnt, e_rd);
    chk({nm, " mem writes"}, wr_cnt, e_wr);
    for (int i = 0; i < e_rd && i < rd_q.size(); i++)
      chk({nm, " refill addr"}, rd_q[i], ((a >> 4) << 2) + i);
    if (e_wr > 0 && wr_cnt > 0) begin
      chk({nm, " waddr"}, w_addr, a >> 2);
      chk({nm, " wstrb"}, 32'(w_strb), 32'(e_strb));
      chk({nm, " wdata"}, w_data, e_wd);
    end
    if (e_err || (m && e_rd == 0)) chk({nm, " latency"}, lat, 1);
  endtask

  task automatic model_run(input string nm, input bit m, input logic [2:0] w, input int a,
                           input logic [31:0] d);
    bit e_err; logic [31:0] e_data, e_wd; int e_rd, e_wr; logic [3:0] e_strb;
    model_step(m, w, a, d, e_err, e_data, e_rd, e_wr, e_strb, e_wd);
    xact(m, w, a, d);
    check_against(nm, m, a, e_err, e_data, e_rd, e_wr, e_strb, e_wd);
  endtask

  typedef struct {
    bit m; logic [2:0] w; int a; logic [31:0] d;
    bit e_err; logic [31:0] e_data; int e_rd; int e_wr; logic [3:0] e_strb; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    bit de; logic [31:0] dd, dw; int dr, dwc; logic [3:0] ds;
    int n;

    tbl[0]  = '{1, 3'd2, 'h000, 0,         0, 32'h0a0a0a0a, 4, 0, 4'h0, 0};
    tbl[1]  = '{1, 3'd2, 'h004, 0,         0, 32'h11111111, 0, 0, 4'h0, 0};
    tbl[2]  = '{0, 3'd1, 'h002, 32'h0b0b,  0, 0,            0, 1, 4'hc, 32'h0b0b0000};
    tbl[3]  = '{1, 3'd2, 'h000, 0,         0, 32'h0b0b0a0a, 0, 0, 4'h0, 0};
    tbl[4]  = '{1, 3'd5, 'h002, 0,         0, 32'h00000b0b, 0, 0, 4'h0, 0};
    tbl[5]  = '{0, 3'd0, 'h001, 32'hf0,    0, 0,            0, 1, 4'h2, 32'h0000f000};
    tbl[6]  = '{1, 3'd0, 'h001, 0,         0, 32'hfffffff0, 0, 0, 4'h0, 0};
    tbl[7]  = '{1, 3'd4, 'h001, 0,         0, 32'h000000f0, 0, 0, 4'h0, 0};
    tbl[8]  = '{1, 3'd2, 'h002, 0,         1, 0,            0, 0, 4'h0, 0};
    tbl[9]  = '{1, 3'd3, 'h000, 0,         1, 0,            0, 0, 4'h0, 0};
    tbl[10] = '{0, 3'd4, 'h000, 0,         1, 0,            0, 0, 4'h0, 0};
    tbl[11] = '{1, 3'd1, 'h003, 0,         1, 0,            0, 0, 4'h0, 0};
    tbl[12] = '{1, 3'd2, 'h100, 0,         0, 32'hc0de0040, 4, 0, 4'h0, 0};
    tbl[13] = '{1, 3'd2, 'h000, 0,         0, 32'h0b0bf00a, 4, 0, 4'h0, 0};
    tbl[14] = '{1, 3'd2, 'h004, 0,         0, 32'h11111111, 0, 0, 4'h0, 0};
    tbl[15] = '{0, 3'd2, 'h208, 32'hdeadbeef, 0, 0,         0, 1, 4'hf, 32'hdeadbeef};
    tbl[16] = '{1, 3'd2, 'h208, 0,         0, 32'hdeadbeef, 4, 0, 4'h0, 0};

    for (int i = 0; i < 1024; i++) bmem[i] = 32'hc0de0000 | i;
    bmem[0] = 32'h0a0a0a0a; bmem[1] = 32'h11111111;
    bmem[2] = 32'h22222222; bmem[3] = 32'h33333333;
    for (int i = 0; i < 1024; i++) ref_mem[i] = bmem[i];
    for (int i = 0; i < NL; i++) begin mv[i] = 0; mt[i] = 0; end

    // reset state
    #12;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset mem_req_valid", 32'(mem_req_valid), 0);
    chk("reset resp_rdata", resp_rdata, 0);
    @(negedge clk); reset_n = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle req_ready", 32'(req_ready), 1);
    chk("idle mem_req_valid", 32'(mem_req_valid), 0);

    // directed table
    for (int i = 0; i < 17; i++) begin
      model_step(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].d, de, dd, dr, dwc, ds, dw);
      xact(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].d);
      check_against($sformatf("vec%0d", i), tbl[i].m, tbl[i].a, tbl[i].e_err, tbl[i].e_data,
                    tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_strb, tbl[i].e_wd);
    end

    // flush invalidates a resident line
    model_run("pre-flush hit", 1, 3'd2, 'h20c, 0);
    @(negedge clk); flush = 1; #1;
    chk("flush req_ready", 32'(req_ready), 0);
    @(negedge clk); flush = 0;
    for (int i = 0; i < NL; i++) mv[i] = 0;
    model_run("post-flush miss", 1, 3'd2, 'h208, 0);
    model_run("refill line0", 1, 3'd2, 'h000, 0);

    // reset in the middle of a refill
    @(negedge clk);
    rd_cnt = 0; rd_q.delete();
    req_valid = 1; req_mode = 1; req_width = 3'd2; req_addr = 12'h100;
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    while (n < 300) begin
      @(negedge clk); #1; n++;
      if (rd_cnt >= 2 && !mem_req_valid && !resp_valid) break;
    end
    chk("reached refill wait", 32'(n < 300), 1);
    reset_n = 0; #1;
    chk("abort mem_req_valid", 32'(mem_req_valid), 0);
    chk("abort req_ready", 32'(req_ready), 1);
    chk("abort resp_valid", 32'(resp_valid), 0);
    @(negedge clk); #1 reset_n = 1;
    for (int i = 0; i < NL; i++) mv[i] = 0;
    model_run("post-reset miss", 1, 3'd2, 'h004, 0);
    model_run("aborted line miss", 1, 3'd2, 'h104, 0);

    // random traffic against the model
    for (int t = 0; t < 250; t++) begin
      bit m; logic [2:0] w; int a; logic [31:0] d;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        for (int i = 0; i < NL; i++) mv[i] = 0;
      end
      m = $urandom_range(0, 1);
      case ($urandom_range(0, 11))
        0, 1, 2: w = 3'd0;
        3, 4:    w = 3'd1;
        5, 6, 7: w = 3'd2;
        8:       w = 3'd4;
        9:       w = 3'd5;
        default: w = 3'($urandom_range(3, 7));
      endcase
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 4) != 0) begin
        if (w[1:0] == 2'b01) a = a & ~1;
        if (w[1:0] == 2'b10) a = a & ~3;
      end
      d = $urandom;
      model_run($sformatf("rnd%0d", t), m, w, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/data_cache_dm.md
Name: data_cache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the core load/store unit and a backing word memory.
- Successor to the flat single-cycle data cache. Adds configurable geometry, a valid/tag array, multi-cycle line refill over a valid/ready memory port, misalignment detection and a flush operation.
- Keeps the existing load/store width encoding and read/write mode convention.

Parameters:
- ADDR_WIDTH, 12: byte-address width.
- LINE_WORDS, 4: 32-bit words per line; power of two, at least 1.
- LINES, 16: number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  invalidate all lines; sampled in IDLE only.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE with flush=0.
- req_mode  in  1  1=read, 0=write.
- req_width  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned. Unsigned codes are legal for reads only.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  single-cycle completion pulse, for reads and writes.
- resp_rdata  out  32  extended load data. Valid with resp_valid on a read; 0 otherwise.
- resp_error  out  1  misaligned address or illegal width; qualified by resp_valid.
- mem_req_valid  out  1  memory request valid.
- mem_req_write  out  1  1=write, 0=read.
- mem_addr  out  ADDR_WIDTH-2  word address.
- mem_wdata  out  32  lane-positioned write data.
- mem_wstrb  out  4  byte strobes; bit i = byte i.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; at most one read outstanding.
- mem_rdata  in  32  read data.

Behaviour:
- Address split, LSB first: 2-bit byte offset, log2(LINE_WORDS) word offset, log2(LINES) index, remaining bits tag.
- Reset, asynchronous: state IDLE; all valid bits 0; all outputs 0 except req_ready=1; refill counter 0. Data and tag arrays are not cleared.
- Reset during any state, including mid-refill, aborts the operation. mem_req_valid drops immediately. The partially filled line stays invalid.
- States:
  - IDLE:
    - flush=1: clear all valid bits; stay in IDLE; req_ready=0 that cycle.
    - req_valid & req_ready: latch the request; go to LOOKUP.
  - LOOKUP:
    - Error check first. An error is: half at an odd address; word at an address not a multiple of 4; width 011, 110 or 111; or width 100/101 with mode=0. On error: resp_valid=1, resp_error=1, resp_rdata=0, no memory traffic, no cache update; go to IDLE.
    - Read hit (valid & tag match): resp_valid=1 with extended data; go to IDLE. Latency is 1 cycle after acceptance.
    - Read miss: counter=0; go to REFILL_REQ.
    - Write (hit or miss): go to WRITE_MEM.
  - REFILL_REQ: mem_req_valid=1, mem_req_write=0, mem_addr={tag,index,counter}. Held stable until mem_ready. Then go to REFILL_WAIT.
  - REFILL_WAIT: on mem_rvalid, store mem_rdata into word[counter].
    - counter < LINE_WORDS-1: counter+1; go to REFILL_REQ.
    - Last word: write tag; set valid; go to LOOKUP. The re-lookup hits and responds.
  - WRITE_MEM: mem_req_valid=1, mem_req_write=1, mem_addr=latched word address, mem_wstrb/mem_wdata lane-positioned. Byte: 1<<off. Half: 0011 or 1100. Word: 1111. Held until mem_ready. In the mem_ready cycle: on a hit, update the masked bytes of the cached word; resp_valid=1, resp_error=0; go to IDLE. A miss leaves the cache unchanged.
- Load extension: select the byte/half by offset.
  - 000 and 001 sign-extend.
  - 100 and 101 zero-extend.
  - 010 returns the word unchanged.
- Throughput: at most one request in flight. req_ready=0 in every state except IDLE.

Test Plan:
- Reset, then idle -> req_ready=1, resp_valid=0, mem_req_valid=0.
- Backing words 0..3 = 0x0a0a0a0a, 0x11111111, 0x22222222, 0x33333333.
  - Read width 010 addr 0x000 -> mem reads word addrs 0,1,2,3 in order; resp_rdata=0x0a0a0a0a.
  - Then read 010 addr 0x004 -> resp_valid 1 cycle after acceptance, data 0x11111111, no mem_req_valid.
- Write 001 data 0x0b0b addr 0x002 -> mem write word addr 0, wstrb=1100, wdata=0x0b0b0000.
  - Read 010 addr 0x000 -> 0x0b0b0a0a (hit).
  - Read 101 addr 0x002 -> 0x00000b0b.
- Write 000 data 0xF0 addr 0x001 -> wstrb=0010.
  - Read 000 addr 0x001 -> 0xFFFFFFF0.
  - Read 100 addr 0x001 -> 0x000000F0.
- Read 010 addr 0x002 -> resp_error=1, no mem traffic. Width 011 -> resp_error=1. Write width 100 -> resp_error=1.
- Read addr 0x100 (index 0, tag 1) -> refill of word addrs 0x40..0x43 evicts line 0; next read 0x000 misses again.
- Then assert flush, or pulse reset_n low during REFILL_WAIT -> the next read 0x004 misses and refills.
